// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: the hex font,
// segment bit positions and the leading-zero blanking helper.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high patterns {dp,g,f,e,d,c,b,a}, dp always clear here.
    localparam logic [7:0] FONT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Blank mask for leading zeros: walks down from digit n-1 while the digit
    // is a zero without a dp; digit 0 is never included.
    function automatic logic [7:0] lz_mask(input logic [31:0] nib,
                                           input logic [7:0]  dps,
                                           input int          n);
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (i < n) begin
                run        = run && (nib[4*i +: 4] == 4'h0) && !dps[i];
                lz_mask[i] = run;
            end
        end
    endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Nibble plus decimal point to active-high segment pattern.
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] pat
);

    always_comb begin
        pat         = FONT[nib];
        pat[SEG_DP] = dp;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: slot/digit counters, frame-synchronous
// shadow capture, blink, leading-zero blanking, PWM brightness, registered pins.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int CLK_DIV        = 50_000,
    parameter int BLINK_DIV      = 250,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int CW   = $clog2(CLK_DIV);
    localparam int IW   = $clog2(DIGITS);
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int STEP = CLK_DIV / 16;

    localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : '0;
    localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       bcnt;
    logic                blink_phase;
    logic                first;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blink;

    logic                cnt_wrap;
    logic                frame_wrap;
    logic [7:0]          lz;
    logic [DIGITS-1:0]   blank_vec;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [7:0]          pat;
    logic [DIGITS-1:0]   sel_on;
    logic                lit;

    assign cnt_wrap   = (cnt == CW'(CLK_DIV - 1));
    assign frame_wrap = cnt_wrap && (idx == IW'(DIGITS - 1));

    assign lz        = lz_mask(32'(sh_data), 8'(sh_dp), DIGITS);
    assign blank_vec = (blank_lz ? lz[DIGITS-1:0] : '0) | (blink_phase ? sh_blink : '0);

    assign cur_nib = sh_data[idx*4 +: 4];
    assign cur_dp  = sh_dp[idx];
    assign sel_on  = DIGITS'(1) << idx;

    // cnt==0 stays dark so the select change never ghosts onto the next digit.
    assign lit = en && (cnt != '0)
              && (32'(cnt) < (32'(bright) + 32'd1) * 32'(STEP))
              && !blank_vec[idx];

    seg_hex_font u_font (
        .nib (cur_nib),
        .dp  (cur_dp),
        .pat (pat)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt         <= '0;
            idx         <= '0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
            first       <= 1'b1;
            sh_data     <= '0;
            sh_dp       <= '0;
            sh_blink    <= '0;
            sel         <= SEL_OFF;
            seg         <= SEG_OFF;
            frame_done  <= 1'b0;
        end else begin
            first      <= 1'b0;
            frame_done <= frame_wrap;
            cnt        <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap)
                idx <= frame_wrap ? '0 : idx + 1'b1;

            // Capture only at frame boundaries so a frame never mixes old/new data.
            if (first || frame_wrap) begin
                sh_data  <= data;
                sh_dp    <= dp;
                sh_blink <= blink_mask;
            end

            if (frame_wrap) begin
                if (bcnt == BW'(BLINK_DIV - 1)) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end

            sel <= lit ? (SEL_ACTIVE_LOW ? ~sel_on : sel_on) : SEL_OFF;
            seg <= lit ? (SEG_ACTIVE_LOW ? ~pat : pat) : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, CLK_DIV=32, BLINK_DIV=2,
// active-low pins; positions are counted in clock edges since reset release.
module tb_seg_scan_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic [3:0]  bright;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    int checks = 0;
    int passed = 0;
    int rel    = 0;

    always #5 sys_clk = ~sys_clk;

    seg_scan_ctrl #(
        .DIGITS(4), .CLK_DIV(32), .BLINK_DIV(2),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .data(data), .dp(dp),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .bright(bright),
        .sel(sel), .seg(seg), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance to the negedge where the outputs show frame f, digit d, slot c.
    task automatic look(input int f, input int d, input int c);
        int target;
        target = f*128 + d*32 + c + 1;
        while (rel < target) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            rel++;
        end
    endtask

    task automatic show(input string tag, input int f, input int d, input int c,
                        input logic [3:0] esel, input logic [7:0] eseg);
        look(f, d, c);
        check({tag, "_sel"}, 32'(sel), 32'(esel));
        check({tag, "_seg"}, 32'(seg), 32'(eseg));
    endtask

    task automatic release_rst();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        rel     = 0;
    endtask

    initial begin
        sys_rst = 1'b1; en = 1'b1; data = 16'h12AF; dp = 4'h0;
        blink_mask = 4'h0; blank_lz = 1'b0; bright = 4'd15;
        repeat (3) @(negedge sys_clk);
        check("rst_sel", 32'(sel), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_fd",  32'(frame_done), 32'h0);

        // Frame 0: data captured at release; a change right after is held off.
        release_rst();
        look(0, 0, 0);
        data = 16'h3456;
        show("f0_d0c0_dark", 0, 0, 0,  4'hF, 8'hFF);
        show("f0_d0c1_F",    0, 0, 1,  4'hE, 8'h8E);
        show("f0_d0c31_F",   0, 0, 31, 4'hE, 8'h8E);
        show("f0_d1c0_dark", 0, 1, 0,  4'hF, 8'hFF);
        show("f0_d1_A",      0, 1, 5,  4'hD, 8'h88);
        show("f0_d2_2",      0, 2, 10, 4'hB, 8'hA4);
        look(0, 3, 30);
        check("fd_low_pre", 32'(frame_done), 32'h0);
        show("f0_d3_1",      0, 3, 31, 4'h7, 8'hF9);
        check("fd_pulse0", 32'(frame_done), 32'h1);
        look(1, 0, 0);
        check("fd_one_cycle", 32'(frame_done), 32'h0);

        // Frame 1: new data; change mid-frame at digit 2 must not tear.
        show("f1_d0_6",      1, 0, 1, 4'hE, 8'h82);
        show("f1_d2_4",      1, 2, 5, 4'hB, 8'h99);
        data = 16'h0005;
        show("f1_d3_3_old",  1, 3, 5, 4'h7, 8'hB0);
        look(1, 3, 31);
        check("fd_pulse1", 32'(frame_done), 32'h1);

        // Frame 2: new value from digit 0; then leading-zero blanking (live).
        show("f2_d0_5",      2, 0, 1, 4'hE, 8'h92);
        blank_lz = 1'b1;
        show("f2_lz_d1",     2, 1, 1, 4'hF, 8'hFF);
        show("f2_lz_d2",     2, 2, 1, 4'hF, 8'hFF);
        show("f2_lz_d3",     2, 3, 1, 4'hF, 8'hFF);
        dp = 4'b0100;

        // Frame 3: dp on digit 2 stops blanking there.
        show("f3_d0_5",      3, 0, 1, 4'hE, 8'h92);
        show("f3_d1_0",      3, 1, 1, 4'hD, 8'hC0);
        show("f3_d2_0dp",    3, 2, 1, 4'hB, 8'h40);
        show("f3_d3_dark",   3, 3, 1, 4'hF, 8'hFF);
        bright = 4'd3;

        // Frame 4: brightness windows.
        show("br3_c7_lit",   4, 0, 7, 4'hE, 8'h92);
        show("br3_c8_dark",  4, 0, 8, 4'hF, 8'hFF);
        show("br3_d1_c3",    4, 1, 3, 4'hD, 8'hC0);
        bright = 4'd0;
        show("br0_dark",     4, 2, 5, 4'hF, 8'hFF);
        bright = 4'd15;

        // Frame 5: enable gating.
        en = 1'b0;
        show("en0_dark",     5, 0, 5, 4'hF, 8'hFF);
        en = 1'b1;
        show("en1_lit",      5, 1, 5, 4'hD, 8'hC0);

        // Reset mid-frame acts immediately.
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("midrst_sel", 32'(sel), 32'hF);
        check("midrst_seg", 32'(seg), 32'hFF);
        check("midrst_fd",  32'(frame_done), 32'h0);

        // Blink: digit 1 dark in frames 2,3 and 6 (0-based), lit otherwise.
        data = 16'h1234; dp = 4'h0; blink_mask = 4'b0010; blank_lz = 1'b0;
        repeat (2) @(negedge sys_clk);
        release_rst();
        show("bl_f0_d1",  0, 1, 10, 4'hD, 8'hB0);
        show("bl_f1_d1",  1, 1, 10, 4'hD, 8'hB0);
        show("bl_f2_d0",  2, 0, 10, 4'hE, 8'h99);
        show("bl_f2_d1",  2, 1, 10, 4'hF, 8'hFF);
        show("bl_f2_d2",  2, 2, 10, 4'hB, 8'hA4);
        show("bl_f3_d1",  3, 1, 10, 4'hF, 8'hFF);
        show("bl_f4_d1",  4, 1, 10, 4'hD, 8'hB0);
        show("bl_f5_d1",  5, 1, 10, 4'hD, 8'hB0);
        show("bl_f6_d1",  6, 1, 10, 4'hF, 8'hFF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
